bsg_swizzle_calib_ctrl: RTL and testbench
=========================================

# bsg_swizzle_calib_ctrl

Sequencer that discovers the pin permutation of one 11-wire comm-link channel (clk, v, data[8:0]) between two chips. It drives a walking-one pattern onto the outgoing channel and samples the incoming channel from a looped-back or partner-driven link. It records where each lane lands, validates that the result is a true permutation, and publishes the map. The map then configures the programmable swizzle stage that sits beside the fixed chip swizzle adapter in the toplevel bsg_chip.

## Interface
- lanes_p, 11: lanes per channel; index 0 = clk, 1 = v, 2+i = data[i].
- hold_cycles_p, 16: cycles each pattern is held, >= 4.
- lg_lanes_lp (localparam): $clog2(lanes_p), 4 at default.
- clk_i  in  1: core clock.
- reset_n_i  in  1: reset; asynchronous, active-low.
- start_i  in  1: calibration request pulse.
- rx_pattern_i  in  lanes_p: incoming channel wires, already synchronized into clk_i.
- tx_pattern_o  out  lanes_p: outgoing channel drive during calibration.
- busy_o  out  1: calibration in progress.
- done_o  out  1: map valid, sticky.
- error_o  out  1: calibration failed, sticky.
- err_lane_o  out  lg_lanes_lp: tx lane at which the failure was detected.
- map_o  out  lanes_p*lg_lanes_lp: slice k = rx lane on which tx lane k arrived.

## Operation
- States: IDLE, DRIVE, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start_i:
  - go to DRIVE with lane = 0, hold counter = 0.
  - Clear done_o, error_o, err_lane_o, and the seen-vector.
  - map_o keeps its old value until overwritten.
- DRIVE:
  - tx_pattern_o = one-hot(lane).
  - The hold counter increments every cycle.
  - When the counter reaches hold_cycles_p-1, rx_pattern_i is sampled that cycle:
    - Exactly one bit j set and seen[j]==0: write map[lane] = j and set seen[j].
      - lane < lanes_p-1: lane++, counter = 0, stay in DRIVE.
      - Otherwise go to CHECK.
    - Zero bits set, more than one bit set, or seen[j] already set: go to ERROR with err_lane_o = lane.
- CHECK (1 cycle): seen == all-ones -> DONE, otherwise ERROR with err_lane_o = lanes_p-1.
- DONE/ERROR: hold their outputs until the next start_i.
- start_i while in DRIVE/CHECK: ignored.
- Reset mid-calibration: asynchronous return to IDLE, all outputs go to reset values, partial map is discarded.
- Outside DRIVE, tx_pattern_o = 0.

## Timing
- Reset values: tx_pattern_o = 0, busy_o = 0, done_o = 0, error_o = 0, err_lane_o = 0, map_o = identity (slice k = k).
- All outputs are registered.
- Cycle 0 is the cycle start_i is sampled high. tx_pattern_o shows lane 0 from cycle 1.
- Lane k is driven during cycles 1+k*hold_cycles_p through (k+1)*hold_cycles_p. It is sampled on the last of those cycles.
- Round-trip channel latency must be <= hold_cycles_p-2 cycles.
- On success:
  - CHECK occupies cycle lanes_p*hold_cycles_p+1.
  - done_o rises at cycle lanes_p*hold_cycles_p+2, which is 178 at default parameters.
  - busy_o falls in the same cycle.
- On failure at lane k: error_o rises at cycle (k+1)*hold_cycles_p+1.
- busy_o is high from cycle 1 through the final CHECK/DRIVE cycle.

## Structure
- Shared package bsg_swizzle_calib_pkg contains:
  - state enum (IDLE, DRIVE, CHECK, DONE, ERROR).
  - lane-index width function.
  - lane constants: clk=0, v=1, data base=2.
- Sub-module bsg_swizzle_onehot_encode:
  - combinational.
  - Inputs: vector lanes_p.
  - Outputs: one_hot flag and encoded index lg_lanes_lp.
  - Used on rx_pattern_i.
- Counters and map registers stay in the top module.

## Test plan
- Identity loopback, 1-cycle delay: map slice k = k, done_o = 1 at cycle 178, error_o = 0.
- Permuted loopback:
  - Permutation tx -> rx: 0->7, 1->0, 2->10, 3->9, 4->8, 5->6, 6->1, 7->4, 8->3, 9->2, 10->5.
  - Required: map_o equals this permutation and done_o = 1.
- Stuck wire: rx lane 3 tied high -> error_o at cycle 17 (lane 0 sees two bits), err_lane_o = 0.
- Open wire: tx lane 5 never arrives -> error_o at cycle 97, err_lane_o = 5, done_o = 0.
- Shorted destination: tx lanes 2 and 4 both land on rx 6 -> error_o at cycle 81, err_lane_o = 4.
- Robustness:
  - reset_n_i low at cycle 50: all outputs return to reset values immediately.
  - A subsequent start_i completes normally.
  - start_i pulsed at cycle 30 has no effect on timing.

Source files
------------

// File: rtl/bsg_swizzle_calib_ctrl_pkg.sv
// bsg_swizzle_calib_pkg
//   Shared definitions for the comm-link swizzle calibration controller:
//   the sequencer state enum, the lane-index width helper and the fixed
//   lane numbering of one channel (clk, v, then data bits).
package bsg_swizzle_calib_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    CHECK,
    DONE,
    ERROR
  } calib_state_e;

  // Lane numbering inside one channel bundle.
  localparam int unsigned LANE_CLK       = 0;
  localparam int unsigned LANE_V         = 1;
  localparam int unsigned LANE_DATA_BASE = 2;

  // Bits needed to name one lane (never less than one bit).
  function automatic int lane_idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/bsg_swizzle_calib_ctrl_if.sv
// bsg_swizzle_calib_ctrl_if
//   Bundles the request/status/pattern signals of the calibration
//   controller.
//   start_i      : calibration request pulse
//   rx_pattern_i : incoming channel wires, already synchronized
//   tx_pattern_o : outgoing channel drive during calibration
//   busy_o       : calibration in progress
//   done_o       : map valid (sticky)
//   error_o      : calibration failed (sticky)
//   err_lane_o   : tx lane at which the failure was detected
//   map_o        : slice k = rx lane on which tx lane k arrived
//   Modports: slave = the controller, master = whoever requests calibration
//   and provides the looped-back channel.
interface bsg_swizzle_calib_ctrl_if
  import bsg_swizzle_calib_pkg::*;
#(
  parameter int lanes_p     = 11,
  parameter int lg_lanes_lp = lane_idx_width(lanes_p)
);

  logic                           start_i;
  logic [lanes_p-1:0]             rx_pattern_i;
  logic [lanes_p-1:0]             tx_pattern_o;
  logic                           busy_o;
  logic                           done_o;
  logic                           error_o;
  logic [lg_lanes_lp-1:0]         err_lane_o;
  logic [lanes_p*lg_lanes_lp-1:0] map_o;

  modport slave (
    input  start_i, rx_pattern_i,
    output tx_pattern_o, busy_o, done_o, error_o, err_lane_o, map_o
  );

  modport master (
    output start_i, rx_pattern_i,
    input  tx_pattern_o, busy_o, done_o, error_o, err_lane_o, map_o
  );

endinterface

// File: rtl/bsg_swizzle_onehot_encode.sv
// bsg_swizzle_onehot_encode
//   Combinational check that a lane vector has exactly one bit set, plus
//   the index of the set bit.
//   vec_i     : lane vector (lanes_p bits)
//   one_hot_o : exactly one bit of vec_i is set
//   idx_o     : index of the highest set bit; meaningful only with one_hot_o
module bsg_swizzle_onehot_encode
  import bsg_swizzle_calib_pkg::*;
#(
  parameter int lanes_p     = 11,
  parameter int lg_lanes_lp = lane_idx_width(lanes_p)
) (
  input  logic [lanes_p-1:0]     vec_i,
  output logic                   one_hot_o,
  output logic [lg_lanes_lp-1:0] idx_o
);

  assign one_hot_o = ($countones(vec_i) == 1);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < lanes_p; i++) begin
      if (vec_i[i]) begin
        idx_o = lg_lanes_lp'(i);
      end
    end
  end

endmodule

// File: rtl/bsg_swizzle_calib_ctrl.sv
// bsg_swizzle_calib_ctrl
//   Discovers the pin permutation of one comm-link channel by walking a
//   single one across the tx lanes, holding each for hold_cycles_p cycles
//   and sampling where it shows up on rx at the end of the hold. The
//   resulting map is published once every rx lane was hit exactly once.
//   clk_i     : core clock
//   reset_n_i : asynchronous active-low reset
//   cal_if    : request, channel patterns, status and map (slave modport)
module bsg_swizzle_calib_ctrl
  import bsg_swizzle_calib_pkg::*;
#(
  parameter int lanes_p       = 11,
  parameter int hold_cycles_p = 16
) (
  input logic                     clk_i,
  input logic                     reset_n_i,
  bsg_swizzle_calib_ctrl_if.slave cal_if
);

  localparam int lg_lanes_lp = lane_idx_width(lanes_p);
  localparam int cnt_w_lp    = lane_idx_width(hold_cycles_p);

  calib_state_e                      state_q, state_d;
  logic [lg_lanes_lp-1:0]            lane_q, lane_d;
  logic [cnt_w_lp-1:0]               cnt_q, cnt_d;
  logic [lanes_p-1:0][lg_lanes_lp-1:0] map_q, map_d;
  logic [lanes_p-1:0]                seen_q, seen_d;
  logic [lanes_p-1:0]                tx_q, tx_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic                              error_q, error_d;
  logic [lg_lanes_lp-1:0]            err_lane_q, err_lane_d;

  logic                              rx_one_hot;
  logic [lg_lanes_lp-1:0]            rx_idx;
  logic                              sample_now;

  bsg_swizzle_onehot_encode #(
    .lanes_p    (lanes_p),
    .lg_lanes_lp(lg_lanes_lp)
  ) u_rx_encode (
    .vec_i    (cal_if.rx_pattern_i),
    .one_hot_o(rx_one_hot),
    .idx_o    (rx_idx)
  );

  // Last cycle of the hold window for the current lane.
  assign sample_now = (cnt_q == cnt_w_lp'(hold_cycles_p - 1));

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    cnt_d      = cnt_q;
    map_d      = map_q;
    seen_d     = seen_q;
    done_d     = done_q;
    error_d    = error_q;
    err_lane_d = err_lane_q;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        // The old map stays visible until each slice is rewritten.
        if (cal_if.start_i) begin
          state_d    = DRIVE;
          lane_d     = '0;
          cnt_d      = '0;
          seen_d     = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_lane_d = '0;
        end
      end

      DRIVE: begin
        if (sample_now) begin
          // A lane is accepted only if it lands on a single, fresh rx wire;
          // a second hit on the same rx wire means two tx lanes are shorted.
          if (rx_one_hot && !seen_q[rx_idx]) begin
            map_d[lane_q]  = rx_idx;
            seen_d[rx_idx] = 1'b1;
            if (lane_q == lg_lanes_lp'(lanes_p - 1)) begin
              state_d = CHECK;
            end else begin
              lane_d = lane_q + lg_lanes_lp'(1);
              cnt_d  = '0;
            end
          end else begin
            state_d    = ERROR;
            error_d    = 1'b1;
            err_lane_d = lane_q;
          end
        end else begin
          cnt_d = cnt_q + cnt_w_lp'(1);
        end
      end

      CHECK: begin
        if (&seen_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = ERROR;
          error_d    = 1'b1;
          err_lane_d = lg_lanes_lp'(lanes_p - 1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    busy_d = (state_d == DRIVE) || (state_d == CHECK);
    tx_d   = '0;
    if (state_d == DRIVE) begin
      tx_d[lane_d] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      cnt_q      <= '0;
      seen_q     <= '0;
      tx_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_lane_q <= '0;
      // Identity map until a calibration says otherwise.
      for (int k = 0; k < lanes_p; k++) begin
        map_q[k] <= lg_lanes_lp'(k);
      end
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_lane_q <= err_lane_d;
      map_q      <= map_d;
    end
  end

  assign cal_if.tx_pattern_o = tx_q;
  assign cal_if.busy_o       = busy_q;
  assign cal_if.done_o       = done_q;
  assign cal_if.error_o      = error_q;
  assign cal_if.err_lane_o   = err_lane_q;
  assign cal_if.map_o        = map_q;

endmodule

// File: tb/tb_bsg_swizzle_calib_ctrl.sv
// tb_bsg_swizzle_calib_ctrl
//   Self-checking bench for bsg_swizzle_calib_ctrl. A channel model maps the
//   tx drive onto rx through a configurable permutation, delay and faults
//   (stuck-high rx wires, an open tx lane, shorts). A lane-level reference
//   model predicts the map, status and completion cycle of each calibration.
module tb_bsg_swizzle_calib_ctrl;

  localparam int LANES = 11;
  localparam int HOLD  = 16;
  localparam int LG    = 4;

  logic clk = 1'b0;
  logic reset_n;

  int total = 0;
  int bad   = 0;

  // Channel configuration.
  int               perm [LANES];
  int               open_lane;
  logic [LANES-1:0] stuck_hi;
  int               delay;
  logic [LANES-1:0] hist [$];

  // Reference copy of the published map.
  int model_map [LANES];

  bsg_swizzle_calib_ctrl_if #(.lanes_p(LANES)) cal_if ();

  bsg_swizzle_calib_ctrl #(
    .lanes_p      (LANES),
    .hold_cycles_p(HOLD)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .cal_if   (cal_if)
  );

  always #5 clk = ~clk;

  // Wire-level view of the link: where each driven tx lane shows up on rx.
  function automatic logic [LANES-1:0] channel(input logic [LANES-1:0] tx);
    logic [LANES-1:0] rx;
    rx = '0;
    for (int k = 0; k < LANES; k++) begin
      if (tx[k] && k != open_lane) rx[perm[k]] = 1'b1;
    end
    return rx | stuck_hi;
  endfunction

  // Loop-back with a delay of 'delay' whole cycles after the half-cycle hop.
  always @(negedge clk) begin
    hist.push_front(channel(cal_if.tx_pattern_o));
    while (hist.size() > 8) void'(hist.pop_back());
    cal_if.rx_pattern_i = (delay < hist.size()) ? hist[delay] : '0;
  end

  function automatic logic [LANES*LG-1:0] pack_map();
    logic [LANES*LG-1:0] p;
    p = '0;
    for (int k = 0; k < LANES; k++) p[k*LG +: LG] = LG'(model_map[k]);
    return p;
  endfunction

  function automatic logic [LANES*LG-1:0] identity_map();
    logic [LANES*LG-1:0] p;
    p = '0;
    for (int k = 0; k < LANES; k++) p[k*LG +: LG] = LG'(k);
    return p;
  endfunction

  function automatic void set_identity();
    for (int k = 0; k < LANES; k++) perm[k] = k;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Lane-by-lane prediction: each tx lane must reach exactly one rx wire
  // that no earlier lane reached; the first lane that does not is reported.
  task automatic model_calib(output bit m_done, output bit m_err,
                             output int m_lane, output int m_cyc);
    bit seen [LANES];
    int hits [$];
    bool_fail: begin end
    for (int j = 0; j < LANES; j++) seen[j] = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_lane = 0;
    m_cyc  = LANES * HOLD + 2;
    for (int k = 0; k < LANES; k++) begin
      hits.delete();
      for (int j = 0; j < LANES; j++) begin
        if ((k != open_lane && perm[k] == j) || stuck_hi[j]) hits.push_back(j);
      end
      if (hits.size() != 1) begin
        m_err = 1'b1; m_lane = k; m_cyc = (k + 1) * HOLD + 1;
        return;
      end
      if (seen[hits[0]]) begin
        m_err = 1'b1; m_lane = k; m_cyc = (k + 1) * HOLD + 1;
        return;
      end
      seen[hits[0]] = 1'b1;
      model_map[k]  = hits[0];
    end
    m_done = 1'b1;
    for (int j = 0; j < LANES; j++) begin
      if (!seen[j]) begin
        m_done = 1'b0; m_err = 1'b1; m_lane = LANES - 1;
      end
    end
  endtask

  // Pulses start (cycle 0) and follows the run until done/error, an optional
  // extra start pulse at glitch_cyc, or a reset applied at reset_cyc.
  task automatic applyStimulus(input int glitch_cyc, input int reset_cyc,
                               output int end_cyc);
    int cyc;
    cyc     = 0;
    end_cyc = -1;
    @(negedge clk);
    cal_if.start_i = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      cyc++;
      cal_if.start_i = (cyc == glitch_cyc);
      if (cyc == 1) begin
        checkOutput("tx_first_lane", 64'(cal_if.tx_pattern_o), 64'd1);
        checkOutput("busy_first", 64'(cal_if.busy_o), 64'd1);
      end
      if (cyc == reset_cyc) begin
        reset_n = 1'b0;
        end_cyc = cyc;
        break;
      end
      if (cal_if.done_o || cal_if.error_o) begin
        end_cyc = cyc;
        break;
      end
    end
    cal_if.start_i = 1'b0;
  endtask

  task automatic runCalibration(input string tag, input int glitch_cyc);
    bit md, me;
    int ml, mc, end_cyc;
    model_calib(md, me, ml, mc);
    applyStimulus(glitch_cyc, 0, end_cyc);
    checkOutput({tag, "_cycle"}, 64'(end_cyc), 64'(mc));
    checkOutput({tag, "_done"}, 64'(cal_if.done_o), 64'(md));
    checkOutput({tag, "_error"}, 64'(cal_if.error_o), 64'(me));
    checkOutput({tag, "_err_lane"}, 64'(cal_if.err_lane_o), 64'(ml));
    checkOutput({tag, "_map"}, 64'(cal_if.map_o), 64'(pack_map()));
    checkOutput({tag, "_busy"}, 64'(cal_if.busy_o), 64'd0);
    checkOutput({tag, "_tx"}, 64'(cal_if.tx_pattern_o), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_held"}, 64'({cal_if.done_o, cal_if.error_o}), 64'({md, me}));
  endtask

  initial begin
    int end_cyc;
    int a, b, tmp;

    reset_n        = 1'b0;
    cal_if.start_i = 1'b0;
    open_lane      = -1;
    stuck_hi       = '0;
    delay          = 1;
    set_identity();
    for (int k = 0; k < LANES; k++) model_map[k] = k;

    repeat (2) @(negedge clk);
    checkOutput("rst_tx", 64'(cal_if.tx_pattern_o), 64'd0);
    checkOutput("rst_busy", 64'(cal_if.busy_o), 64'd0);
    checkOutput("rst_done", 64'(cal_if.done_o), 64'd0);
    checkOutput("rst_error", 64'(cal_if.error_o), 64'd0);
    checkOutput("rst_err_lane", 64'(cal_if.err_lane_o), 64'd0);
    checkOutput("rst_map", 64'(cal_if.map_o), 64'(identity_map()));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] identity loopback");
    runCalibration("identity", 0);

    $display("[TB] permuted loopback");
    perm = '{7, 0, 10, 9, 8, 6, 1, 4, 3, 2, 5};
    runCalibration("permuted", 0);

    $display("[TB] stuck rx lane 3");
    set_identity();
    stuck_hi = 11'b000_0000_1000;
    runCalibration("stuck", 0);
    stuck_hi = '0;

    $display("[TB] open tx lane 5");
    open_lane = 5;
    runCalibration("open", 0);
    open_lane = -1;

    $display("[TB] tx lanes 2 and 4 shorted onto rx 6");
    perm[2] = 6;
    perm[4] = 6;
    runCalibration("short", 0);
    set_identity();

    $display("[TB] stray start during calibration");
    runCalibration("glitch", 30);

    $display("[TB] reset during calibration");
    perm = '{7, 0, 10, 9, 8, 6, 1, 4, 3, 2, 5};
    applyStimulus(0, 50, end_cyc);
    #1;
    checkOutput("midrst_cycle", 64'(end_cyc), 64'd50);
    checkOutput("midrst_tx", 64'(cal_if.tx_pattern_o), 64'd0);
    checkOutput("midrst_busy", 64'(cal_if.busy_o), 64'd0);
    checkOutput("midrst_done", 64'(cal_if.done_o), 64'd0);
    checkOutput("midrst_error", 64'(cal_if.error_o), 64'd0);
    checkOutput("midrst_err_lane", 64'(cal_if.err_lane_o), 64'd0);
    checkOutput("midrst_map", 64'(cal_if.map_o), 64'(identity_map()));
    for (int k = 0; k < LANES; k++) model_map[k] = k;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    runCalibration("after_reset", 0);

    $display("[TB] randomized channels");
    for (int r = 0; r < 6; r++) begin
      set_identity();
      for (int i = LANES - 1; i > 0; i--) begin
        a       = $urandom_range(0, i);
        tmp     = perm[i];
        perm[i] = perm[a];
        perm[a] = tmp;
      end
      delay     = $urandom_range(0, 3);
      open_lane = -1;
      stuck_hi  = '0;
      case ($urandom_range(0, 3))
        1: stuck_hi[$urandom_range(0, LANES - 1)] = 1'b1;
        2: open_lane = $urandom_range(0, LANES - 1);
        3: begin
          a       = $urandom_range(0, LANES - 2);
          b       = $urandom_range(a + 1, LANES - 1);
          perm[b] = perm[a];
        end
        default: ;
      endcase
      runCalibration($sformatf("rand%0d", r), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
